// File: rtl/carry_pipe_add_if.sv
// carry_pipe_add_if
//   Bundles the operand/result signals of the pipelined carry adder.
//   master : the operand producer / result consumer (drives CE, VALID_IN,
//            A, B, SUB, CI; observes VALID_OUT, SUM, CO, OVF).
//   slave  : the adder itself.
interface carry_pipe_add_if #(
  parameter int WIDTH = 32
);
  logic             CE;
  logic             VALID_IN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic             CI;
  logic             VALID_OUT;
  logic [WIDTH-1:0] SUM;
  logic             CO;
  logic             OVF;

  modport master (
    output CE, VALID_IN, A, B, SUB, CI,
    input  VALID_OUT, SUM, CO, OVF
  );

  modport slave (
    input  CE, VALID_IN, A, B, SUB, CI,
    output VALID_OUT, SUM, CO, OVF
  );
endinterface

// File: rtl/carry_pipe_add.sv
// carry_pipe_add
//   Pipelined adder/subtractor built from 8-bit carry slices. Slice k is
//   evaluated in pipeline stage k; its carry is registered and consumed by
//   slice k+1 one enabled cycle later. Operand bits of the upper slices ride
//   along in skew registers, finished result bits ride along in deskew
//   registers, so a whole result appears on SUM after NSLICE enabled cycles.
// Ports
//   CLK : rising-edge clock
//   CLR : asynchronous active-high clear of all state
//   bus : carry_pipe_add_if.slave (CE, VALID_IN, A, B, SUB, CI in;
//         VALID_OUT, SUM, CO, OVF out)
module carry_pipe_add #(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 CLR,
  carry_pipe_add_if.slave      bus
);

  localparam int NSLICE = WIDTH / 8;

  // One 8-bit slice of the carry chain. Returns {carry_out, sum[7:0]}.
  // B is inverted by sub before entering the chain.
  function automatic logic [8:0] slice_add(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       sub,
    input logic       cin
  );
    logic [7:0] o;
    logic       c;
    logic       s;
    o = 8'h00;
    c = cin;
    for (int i = 0; i < 8; i++) begin
      s    = a[i] ^ b[i] ^ sub;
      o[i] = s ^ c;
      c    = s ? c : a[i];
    end
    return {c, o};
  endfunction

  // Next-state of the output stage, produced by whichever branch below
  // evaluates the last slice.
  logic [WIDTH-1:0] sum_d;
  logic             co_d;
  logic             ovf_d;
  logic             vld_d;

  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             ovf_q;
  logic             vld_q;

  if (NSLICE == 1) begin : g_single
    logic [8:0] sl_s;

    assign sl_s  = slice_add(bus.A[7:0], bus.B[7:0], bus.SUB, bus.CI);
    assign sum_d = sl_s[7:0];
    assign co_d  = sl_s[8];
    // Carry into the MSB is recovered as sum ^ propagate of that bit.
    assign ovf_d = sl_s[7] ^ bus.A[7] ^ bus.B[7] ^ bus.SUB ^ sl_s[8];
    assign vld_d = bus.VALID_IN;
  end else begin : g_multi
    // Boundary k sits between stage k-1 and stage k. It holds the operand
    // bits of slices k..NSLICE-1 (skew) and result bits of slices 0..k-1
    // (deskew), plus the carry, SUB flag and valid bit of that operation.
    for (genvar k = 1; k < NSLICE; k++) begin : g_bnd
      localparam int OW = WIDTH - 8 * k;
      localparam int RW = 8 * k;

      logic [OW-1:0] a_d,   a_q;
      logic [OW-1:0] b_d,   b_q;
      logic [RW-1:0] res_d, res_q;
      logic          cy_d,  cy_q;
      logic          sub_d, sub_q;
      logic          vld_d, vld_q;
      logic [8:0]    sl_s;

      if (k == 1) begin : g_src
        assign sl_s  = slice_add(bus.A[7:0], bus.B[7:0], bus.SUB, bus.CI);
        assign a_d   = bus.A[WIDTH-1:8];
        assign b_d   = bus.B[WIDTH-1:8];
        assign res_d = sl_s[7:0];
        assign sub_d = bus.SUB;
        assign vld_d = bus.VALID_IN;
      end else begin : g_src
        assign sl_s  = slice_add(g_bnd[k-1].a_q[7:0], g_bnd[k-1].b_q[7:0],
                                 g_bnd[k-1].sub_q, g_bnd[k-1].cy_q);
        assign a_d   = g_bnd[k-1].a_q[OW+7:8];
        assign b_d   = g_bnd[k-1].b_q[OW+7:8];
        assign res_d = {sl_s[7:0], g_bnd[k-1].res_q};
        assign sub_d = g_bnd[k-1].sub_q;
        assign vld_d = g_bnd[k-1].vld_q;
      end
      assign cy_d = sl_s[8];

      // Boundary registers: cleared by CLR, loaded on every enabled cycle.
      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
          cy_q  <= 1'b0;
          sub_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (bus.CE) begin
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
          cy_q  <= cy_d;
          sub_q <= sub_d;
          vld_q <= vld_d;
        end
      end
    end

    // Last slice reads the final boundary and completes the result.
    logic [8:0] sl_s;
    logic [7:0] a_top_s;
    logic [7:0] b_top_s;
    logic       sub_top_s;

    assign a_top_s   = g_bnd[NSLICE-1].a_q;
    assign b_top_s   = g_bnd[NSLICE-1].b_q;
    assign sub_top_s = g_bnd[NSLICE-1].sub_q;
    assign sl_s      = slice_add(a_top_s, b_top_s, sub_top_s, g_bnd[NSLICE-1].cy_q);
    assign sum_d     = {sl_s[7:0], g_bnd[NSLICE-1].res_q};
    assign co_d      = sl_s[8];
    assign ovf_d     = sl_s[7] ^ a_top_s[7] ^ b_top_s[7] ^ sub_top_s ^ sl_s[8];
    assign vld_d     = g_bnd[NSLICE-1].vld_q;
  end

  // Output registers: cleared by CLR, frozen while CE is low.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sum_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (bus.CE) begin
      sum_q <= sum_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign bus.SUM       = sum_q;
  assign bus.CO        = co_q;
  assign bus.OVF       = ovf_q;
  assign bus.VALID_OUT = vld_q;

endmodule

// File: tb/tb_carry_pipe_add.sv
module tb_carry_pipe_add;

  localparam int W = 32;
  localparam int NV = 12;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  carry_pipe_add_if #(.WIDTH(W)) bus ();

  carry_pipe_add #(.WIDTH(W)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        ci;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic sub, input logic ci);
    bus.CE       = ce;
    bus.VALID_IN = v;
    bus.A        = a;
    bus.B        = b;
    bus.SUB      = sub;
    bus.CI       = ci;
  endtask

  task automatic drive_vec(input int i);
    drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare VALID_OUT, and the result fields when a result is expected.
  task automatic chk_out(input string name, input logic ev, input logic [31:0] es,
                         input logic eco, input logic eovf);
    chk({name, ".valid"}, {31'd0, bus.VALID_OUT}, {31'd0, ev});
    if (ev) begin
      chk({name, ".sum"}, bus.SUM, es);
      chk({name, ".co"},  {31'd0, bus.CO},  {31'd0, eco});
      chk({name, ".ovf"}, {31'd0, bus.OVF}, {31'd0, eovf});
    end
  endtask

  task automatic chk_vec(input string name, input int i);
    chk_out(name, 1'b1, vecs[i].sum, vecs[i].co, vecs[i].ovf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[10] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[11] = '{32'h00000010, 32'h00000010, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    // Reset state
    clr = 1'b1;
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    step();
    step();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.sum", bus.SUM, 32'h00000000);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 clr = 1'b0;
    step();
    chk_out("post_reset", 1'b0, 32'h0, 1'b0, 1'b0);

    // Single operation: exactly four enabled cycles of latency
    drive_vec(0);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_out("lat.c1", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_out("lat.c2", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_out("lat.c3", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_vec("lat.c4", 0);
    step();
    chk_out("lat.c5", 1'b0, 32'h0, 1'b0, 1'b0);

    // Table of vectors streamed back-to-back
    for (int c = 0; c <= NV + 3; c++) begin
      if (c < NV) drive_vec(c);
      else drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      if (c >= 3 && c - 3 < NV) chk_vec($sformatf("stream[%0d]", c - 3), c - 3);
      else chk_out($sformatf("stream.idle%0d", c), 1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Four ops back-to-back, then a 3-cycle stall with junk VALID_IN
    for (int i = 0; i < 4; i++) begin
      drive_vec(i + 1);
      step();
      if (i < 3) chk_out("stall.fill", 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk_vec("stall.op0", 1);
    drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec($sformatf("stall.frozen%0d", i), 1);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_vec("stall.op1", 2);
    step();
    chk_vec("stall.op2", 3);
    step();
    chk_vec("stall.op3", 4);
    step();
    chk_out("stall.drain", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_out("stall.drain2", 1'b0, 32'h0, 1'b0, 1'b0);

    // CLR with one result on the output and three operations in flight
    drive_vec(5);
    step();
    drive_vec(6);
    step();
    drive_vec(7);
    step();
    drive_vec(9);
    step();
    chk_vec("clr.pre", 5);
    #2 clr = 1'b1;
    #1;
    chk_out("clr.async", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr.async.sum", bus.SUM, 32'h00000000);
    chk("clr.async.co",  {31'd0, bus.CO},  32'd0);
    chk("clr.async.ovf", {31'd0, bus.OVF}, 32'd0);
    step();
    step();
    chk_out("clr.held", 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("clr.nostale%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
    end
    drive_vec(2);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      chk_out($sformatf("clr.relat%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    chk_vec("clr.relat4", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
